// File: rtl/sram_upload_reader.sv
// sram_upload_reader: serves data_io upload bytes out of the board SRAM, fetching each byte
// ahead of the read strobe that consumes it.
module sram_upload_reader #(
    parameter logic [18:0] BASE_ADDR = 19'h0,
    parameter logic [18:0] UPL_LEN   = 19'h7FFFF,
    parameter int unsigned SETTLE    = 2
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_upload,
    input  logic        ioctl_rd,
    output logic [7:0]  ioctl_din,
    output logic        din_valid,
    output logic        sram_req,
    input  logic        sram_gnt,
    output logic [18:0] sram_addr,
    input  logic [7:0]  sram_dq_in,
    output logic        overrun
);
    typedef enum logic [2:0] {StIdle, StReq, StAddr, StCapt, StReady} state_e;

    localparam logic [1:0] SettleLoad = 2'(SETTLE - 1);

    state_e      r_state, w_state_nxt;
    logic [18:0] r_idx, w_idx_nxt;
    logic [18:0] r_addr, w_addr_nxt;
    logic [1:0]  r_cnt, w_cnt_nxt;
    logic [7:0]  r_din, w_din_nxt;
    logic        r_dv, w_dv_nxt;
    logic        r_pend, w_pend_nxt;
    logic        r_ovr, w_ovr_nxt;
    logic        r_upl;

    logic        w_past_end;
    logic [18:0] w_idx_inc;

    assign w_past_end = (r_idx >= UPL_LEN);
    // Index saturates so the tail of the address space keeps returning FF.
    assign w_idx_inc  = (r_idx == '1) ? r_idx : r_idx + 19'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_addr_nxt  = r_addr;
        w_cnt_nxt   = r_cnt;
        w_din_nxt   = r_din;
        w_dv_nxt    = r_dv;
        w_pend_nxt  = r_pend;
        w_ovr_nxt   = r_ovr;
        if (r_state != StIdle && !ioctl_upload) begin
            w_state_nxt = StIdle;
            w_dv_nxt    = 1'b0;
            w_pend_nxt  = 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (ioctl_upload && !r_upl) begin
                        w_idx_nxt   = '0;
                        w_ovr_nxt   = 1'b0;
                        w_pend_nxt  = 1'b0;
                        w_state_nxt = StReq;
                    end
                end
                StReq: begin
                    if (w_past_end) begin
                        w_din_nxt   = 8'hFF;
                        w_dv_nxt    = 1'b1;
                        w_state_nxt = StReady;
                    end else if (sram_gnt) begin
                        w_addr_nxt  = BASE_ADDR + r_idx;
                        w_cnt_nxt   = SettleLoad;
                        w_state_nxt = StAddr;
                    end
                end
                StAddr: begin
                    if (!sram_gnt) begin
                        w_state_nxt = StReq;
                    end else if (r_cnt == 2'd0) begin
                        w_state_nxt = StCapt;
                    end else begin
                        w_cnt_nxt = r_cnt - 2'd1;
                    end
                end
                StCapt: begin
                    w_din_nxt   = sram_dq_in;
                    w_dv_nxt    = 1'b1;
                    w_state_nxt = StReady;
                end
                StReady: begin
                    // A strobe taken during the fetch consumes this byte immediately.
                    if (ioctl_rd || r_pend) begin
                        w_dv_nxt    = 1'b0;
                        w_pend_nxt  = 1'b0;
                        w_idx_nxt   = w_idx_inc;
                        w_state_nxt = StReq;
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
            if (ioctl_rd && r_state != StIdle) begin
                if (r_pend) begin
                    w_ovr_nxt = 1'b1;
                end else if (r_state != StReady) begin
                    w_pend_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_idx   <= '0;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_din   <= 8'hFF;
            r_dv    <= 1'b0;
            r_pend  <= 1'b0;
            r_ovr   <= 1'b0;
            r_upl   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_addr  <= w_addr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_din   <= w_din_nxt;
            r_dv    <= w_dv_nxt;
            r_pend  <= w_pend_nxt;
            r_ovr   <= w_ovr_nxt;
            r_upl   <= ioctl_upload;
        end
    end

    // Bus is held from request through the capture edge; past-end reads never request.
    assign sram_req  = (r_state == StAddr) || (r_state == StCapt) ||
                       (r_state == StReq && !w_past_end);
    assign sram_addr = r_addr;
    assign ioctl_din = r_din;
    assign din_valid = r_dv;
    assign overrun   = r_ovr;

endmodule
